wb_bridge_arbiter: RTL and testbench
====================================

# wb_bridge_arbiter

Round-robin arbiter that shares the single Wishbone slave port of the WB-to-AHB bridge among NMAS Wishbone masters. It sits directly in front of the bridge. It grants one master at a time and holds the grant for the master's whole cyc_i cycle, including block transfers. It routes ack and read data back to the owner, and aborts a stalled cycle with an error after a programmable timeout.

## Interface
- NMAS, 4: number of Wishbone masters (2..8)
- AWIDTH, 32: address width
- DWIDTH, 32: data width
- TIMEOUT, 64: cycles in GRANT with stb high and no ack before abort (>=2)
- clk_i  in  1  single clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- m_cyc_i  in  NMAS  per-master cycle request
- m_stb_i  in  NMAS  per-master strobe
- m_we_i  in  NMAS  per-master write enable
- m_sel_i  in  4*NMAS  byte selects, master k at [4k+3:4k]
- m_addr_i  in  AWIDTH*NMAS  addresses, master k at [AWIDTH*k +: AWIDTH]
- m_data_i  in  DWIDTH*NMAS  write data, packed as m_addr_i
- m_data_o  out  DWIDTH  read data, broadcast to all masters
- m_ack_o  out  NMAS  per-master acknowledge
- m_err_o  out  NMAS  per-master timeout error, one-cycle pulse
- gnt_o  out  NMAS  one-hot current owner (status)
- s_cyc_o, s_stb_o, s_we_o  out  1  to bridge cyc_i/stb_i/we_i
- s_sel_o  out  4  to bridge sel_i
- s_addr_o  out  AWIDTH  to bridge addr_i
- s_data_o  out  DWIDTH  to bridge data_i
- s_data_i  in  DWIDTH  from bridge data_o
- s_ack_i  in  1  from bridge ack_o

## Operation
- States:
  - IDLE: no owner; all s_* outputs 0.
  - GRANT: owner registered.
  - ABORT: one cycle, timeout error.
- IDLE -> GRANT: any m_cyc_i set at a clock edge. The owner is the first requester at or after index ptr, scanning upward with wrap.
- GRANT:
  - s_cyc_o/s_stb_o/s_we_o/s_sel_o/s_addr_o/s_data_o = owner's inputs, combinational mux on the registered owner.
  - m_ack_o[owner] = s_ack_i. All other acks are 0.
  - m_data_o = s_data_i at all times.
- GRANT -> IDLE when owner m_cyc_i=0 at an edge. ptr <= owner+1 mod NMAS.
- Timeout counter:
  - Clears on entry to GRANT, on s_ack_i, and whenever owner stb is low.
  - Increments otherwise.
  - At count == TIMEOUT-1 with no ack: GRANT -> ABORT.
- ABORT:
  - s_cyc_o=s_stb_o=0.
  - m_err_o[owner]=1.
  - Next state is IDLE and ptr <= owner+1.
- Non-owner requests are ignored until IDLE. Masters keep cyc_i asserted while waiting.
- A master's cyc_i dropping while it is not the owner has no effect.

## Timing
- Reset (async): state IDLE, ptr 0, counter 0, gnt_o 0. All s_* outputs, m_ack_o and m_err_o are 0 immediately. m_data_o follows s_data_i.
- Grant latency:
  - Request sampled at edge n gives GRANT and gnt_o from n, visible after edge n.
  - s_cyc_o rises in the same cycle as gnt_o.
- Re-arbitration bubble: at least one IDLE cycle between owners, so the bridge drives htrans IDLE. No back-to-back grants, even when a release and a new request coincide.
- Release and ack in the same cycle: the ack is passed through that cycle, then IDLE.
- Timeout and ack coincide at the final count: the ack wins, the counter clears, and there is no abort.
- Only one master requesting: after release, it is regranted after the one-cycle bubble.
- Reset mid-transfer: the bus drops in the same cycle. The interrupted master sees no ack and no err.

## Structure
- Package wb_arb_pkg: state encoding constants ST_IDLE=2'd0, ST_GRANT=2'd1, ST_ABORT=2'd2, and default NMAS/TIMEOUT.
- Sub-module rr_picker (purely combinational), parameter N:
  - Inputs: req[N], ptr[log2 N].
  - Outputs: one-hot gnt and its binary index.
  - Reused by other arbiters in the SoC.
- Top module: FSM, pointer, counter, owner register, and the output muxes.

## Test plan
- Reset, then m_cyc_i=4'b0101 at once -> master 0 granted (ptr 0). After it releases: 1 IDLE cycle, then master 2 granted.
- Masters 1 and 3 both continuously requesting, each doing a single write -> grant order 1,3,1,3. One IDLE cycle between each. s_addr_o matches the owner every GRANT cycle.
- Master 2 does a 4-beat read block with cyc_i held and the bridge acking every other cycle -> m_ack_o[2] mirrors s_ack_i. m_data_o equals s_data_i on ack cycles. Master 0 requesting is not granted until master 2 drops cyc_i.
- TIMEOUT=8, owner stb high, s_ack_i held 0 -> ABORT after 8 GRANT cycles. m_err_o[owner] pulses 1 cycle, s_cyc_o=0, then IDLE and ptr advances.
- s_ack_i arrives exactly at count 7 with TIMEOUT=8 -> no error, transfer completes normally.
- rst_i asserted asynchronously mid-write -> s_cyc_o, gnt_o and m_ack_o go to 0 before the next edge. After reset is released, master 0 has priority.

Source files
------------

// File: rtl/wb_bridge_arbiter_pkg.sv
// Shared types and defaults for the Wishbone bridge arbiter.
package wb_arb_pkg;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_ABORT = 2'd2
    } arb_state_e;

    localparam int DEF_NMAS    = 4;
    localparam int DEF_TIMEOUT = 64;
endpackage

// File: rtl/wb_bridge_arbiter_if.sv
// Bus bundle between NMAS Wishbone masters, the arbiter and the WB-to-AHB bridge.
interface wb_bridge_arbiter_if #(
    parameter int NMAS   = 4,
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
);
    logic [NMAS-1:0]        m_cyc_i;
    logic [NMAS-1:0]        m_stb_i;
    logic [NMAS-1:0]        m_we_i;
    logic [4*NMAS-1:0]      m_sel_i;
    logic [AWIDTH*NMAS-1:0] m_addr_i;
    logic [DWIDTH*NMAS-1:0] m_data_i;
    logic [DWIDTH-1:0]      m_data_o;
    logic [NMAS-1:0]        m_ack_o;
    logic [NMAS-1:0]        m_err_o;
    logic [NMAS-1:0]        gnt_o;
    logic                   s_cyc_o;
    logic                   s_stb_o;
    logic                   s_we_o;
    logic [3:0]             s_sel_o;
    logic [AWIDTH-1:0]      s_addr_o;
    logic [DWIDTH-1:0]      s_data_o;
    logic [DWIDTH-1:0]      s_data_i;
    logic                   s_ack_i;

    // Arbiter side: slave to the masters, driver of the bridge port.
    modport slave (
        input  m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_addr_i, m_data_i, s_data_i, s_ack_i,
        output m_data_o, m_ack_o, m_err_o, gnt_o,
        output s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_addr_o, s_data_o
    );

    // Environment side: the masters plus the bridge.
    modport master (
        output m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_addr_i, m_data_i, s_data_i, s_ack_i,
        input  m_data_o, m_ack_o, m_err_o, gnt_o,
        input  s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_addr_o, s_data_o
    );
endinterface

// File: rtl/wb_bridge_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester at or above ptr, with wrap.
module rr_picker #(
    parameter int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] idx
);
    int   j;
    logic found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int i = 0; i < N; i++) begin
            j = (int'(ptr) + i) % N;
            if (!found && req[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = W'(j);
            end
        end
    end
endmodule

// File: rtl/wb_bridge_arbiter.sv
// Round-robin arbiter sharing the bridge's single Wishbone slave port among NMAS
// masters; holds the grant for a whole cyc cycle and aborts stalled cycles.
module wb_bridge_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NMAS    = DEF_NMAS,
    parameter int AWIDTH  = 32,
    parameter int DWIDTH  = 32,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input logic               clk_i,
    input logic               rst_i,
    wb_bridge_arbiter_if.slave bus
);
    localparam int PW = $clog2(NMAS);
    localparam int CW = $clog2(TIMEOUT);

    arb_state_e      state, state_nx;
    logic [PW-1:0]   ptr, ptr_nx, owner, owner_nx, owner_inc, pick_idx;
    logic [NMAS-1:0] own_oh, own_oh_nx, pick_gnt;
    logic [CW-1:0]   cnt, cnt_nx;

    rr_picker #(.N(NMAS)) u_pick (
        .req (bus.m_cyc_i),
        .ptr (ptr),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

    assign owner_inc = (owner == PW'(NMAS - 1)) ? '0 : owner + 1'b1;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= ST_IDLE;
            ptr    <= '0;
            owner  <= '0;
            own_oh <= '0;
            cnt    <= '0;
        end else begin
            state  <= state_nx;
            ptr    <= ptr_nx;
            owner  <= owner_nx;
            own_oh <= own_oh_nx;
            cnt    <= cnt_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        ptr_nx    = ptr;
        owner_nx  = owner;
        own_oh_nx = own_oh;
        cnt_nx    = cnt;
        case (state)
            ST_IDLE: begin
                cnt_nx = '0;
                if (|bus.m_cyc_i) begin
                    state_nx  = ST_GRANT;
                    owner_nx  = pick_idx;
                    own_oh_nx = pick_gnt;
                end
            end
            ST_GRANT: begin
                // Release beats timeout; an ack at the final count saves the cycle.
                if (!bus.m_cyc_i[owner]) begin
                    state_nx = ST_IDLE;
                    ptr_nx   = owner_inc;
                end else if (bus.s_ack_i || !bus.m_stb_i[owner]) begin
                    cnt_nx = '0;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    state_nx = ST_ABORT;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            ST_ABORT: begin
                state_nx = ST_IDLE;
                ptr_nx   = owner_inc;
                cnt_nx   = '0;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign bus.m_data_o = bus.s_data_i;

    always_comb begin
        bus.gnt_o    = '0;
        bus.m_ack_o  = '0;
        bus.m_err_o  = '0;
        bus.s_cyc_o  = 1'b0;
        bus.s_stb_o  = 1'b0;
        bus.s_we_o   = 1'b0;
        bus.s_sel_o  = '0;
        bus.s_addr_o = '0;
        bus.s_data_o = '0;
        if (state == ST_GRANT) begin
            bus.gnt_o    = own_oh;
            bus.m_ack_o  = own_oh & {NMAS{bus.s_ack_i}};
            bus.s_cyc_o  = bus.m_cyc_i[owner];
            bus.s_stb_o  = bus.m_stb_i[owner];
            bus.s_we_o   = bus.m_we_i[owner];
            bus.s_sel_o  = bus.m_sel_i[owner*4 +: 4];
            bus.s_addr_o = bus.m_addr_i[owner*AWIDTH +: AWIDTH];
            bus.s_data_o = bus.m_data_i[owner*DWIDTH +: DWIDTH];
        end else if (state == ST_ABORT) begin
            bus.m_err_o = own_oh;
        end
    end
endmodule

// File: tb/tb_wb_bridge_arbiter.sv
// Randomized + directed bench for wb_bridge_arbiter against a cycle-level reference model.
module tb_wb_bridge_arbiter;
    localparam int NM = 4;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NM-1:0]    cyc = '0, stb = '0, we = '0;
    logic [4*NM-1:0]  sel = '0;
    logic [32*NM-1:0] addr = '0, wdat = '0;
    logic [31:0]      sdat = '0;
    logic             sack = 1'b0;

    wb_bridge_arbiter_if #(.NMAS(NM), .AWIDTH(32), .DWIDTH(32)) bus ();

    assign bus.m_cyc_i  = cyc;
    assign bus.m_stb_i  = stb;
    assign bus.m_we_i   = we;
    assign bus.m_sel_i  = sel;
    assign bus.m_addr_i = addr;
    assign bus.m_data_i = wdat;
    assign bus.s_data_i = sdat;
    assign bus.s_ack_i  = sack;

    wb_bridge_arbiter #(.NMAS(NM), .AWIDTH(32), .DWIDTH(32), .TIMEOUT(TO)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int nchk = 0;
    int nerr = 0;

    // Reference model: who owns the bus, whether it is being aborted, the
    // round-robin start point and how long the owner has been stalled.
    int md_owner = -1;
    bit md_abort = 1'b0;
    int md_ptr   = 0;
    int md_stall = 0;
    logic [NM-1:0] exp_ack = '0, exp_err = '0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nchk++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        md_owner = -1;
        md_abort = 1'b0;
        md_ptr   = 0;
        md_stall = 0;
    endtask

    function automatic logic exp_stb();
        return (md_owner >= 0 && !md_abort) ? stb[md_owner] : 1'b0;
    endfunction

    task automatic check_outputs();
        logic [NM-1:0] eg, ea, ee;
        logic          ec, es, ew;
        logic [3:0]    esel;
        logic [31:0]   eadr, edat;
        eg = '0; ea = '0; ee = '0; ec = 0; es = 0; ew = 0;
        esel = '0; eadr = '0; edat = '0;
        if (md_owner >= 0) begin
            if (md_abort) ee[md_owner] = 1'b1;
            else begin
                eg[md_owner] = 1'b1;
                ea[md_owner] = sack;
                ec   = cyc[md_owner];
                es   = stb[md_owner];
                ew   = we[md_owner];
                esel = sel[md_owner*4 +: 4];
                eadr = addr[md_owner*32 +: 32];
                edat = wdat[md_owner*32 +: 32];
            end
        end
        chk("gnt", bus.gnt_o, eg);
        chk("m_ack", bus.m_ack_o, ea);
        chk("m_err", bus.m_err_o, ee);
        chk("s_cyc", bus.s_cyc_o, ec);
        chk("s_stb", bus.s_stb_o, es);
        chk("s_we", bus.s_we_o, ew);
        chk("s_sel", bus.s_sel_o, esel);
        chk("s_addr", bus.s_addr_o, eadr);
        chk("s_data", bus.s_data_o, edat);
        chk("m_data", bus.m_data_o, sdat);
        exp_ack = ea;
        exp_err = ee;
    endtask

    task automatic model_step();
        if (rst) begin
            model_reset();
        end else if (md_owner < 0) begin
            if (cyc != '0) begin
                for (int i = 0; i < NM; i++) begin
                    int j;
                    j = (md_ptr + i) % NM;
                    if (cyc[j]) begin
                        md_owner = j;
                        break;
                    end
                end
                md_stall = 0;
            end
        end else if (md_abort) begin
            md_ptr   = (md_owner + 1) % NM;
            md_owner = -1;
            md_abort = 1'b0;
        end else if (!cyc[md_owner]) begin
            md_ptr   = (md_owner + 1) % NM;
            md_owner = -1;
        end else if (sack || !stb[md_owner]) begin
            md_stall = 0;
        end else if (md_stall == TO - 1) begin
            md_abort = 1'b1;
        end else begin
            md_stall++;
        end
    endtask

    // One clock: compare at the falling edge, advance the model at the rising edge.
    task automatic cycle();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_master_addrs();
        for (int k = 0; k < NM; k++) begin
            addr[k*32 +: 32] = 32'h1000_0040 + 32'(k * 'h100);
            wdat[k*32 +: 32] = 32'hD000_0000 + 32'(k);
            sel[k*4 +: 4]    = 4'hF;
        end
    endtask

    // Random-phase master agents
    bit [NM-1:0] act = '0;
    int          beats [NM];
    int          stall = 0;

    initial begin
        set_master_addrs();
        #1;
        chk("rst_gnt", bus.gnt_o, 4'b0000);
        chk("rst_scyc", bus.s_cyc_o, 1'b0);
        chk("rst_ack", bus.m_ack_o, 4'b0000);
        cycle();
        cycle();
        rst = 1'b0;

        // Two requesters at once: master 0 wins from ptr 0, then master 2 after a bubble.
        cyc = 4'b0101; stb = 4'b0101; we = 4'b0101;
        cycle();
        chk("t1_gnt0", bus.gnt_o, 4'b0001);
        sack = 1'b1;
        cycle();
        sack = 1'b0; cyc = 4'b0100; stb = 4'b0100;
        cycle();
        chk("t1_bubble", bus.gnt_o, 4'b0000);
        cycle();
        chk("t1_gnt2", bus.gnt_o, 4'b0100);
        sack = 1'b1;
        cycle();
        sack = 1'b0; cyc = '0; stb = '0;
        cycle();

        // Timeout: master 0 strobes with no ack.
        cyc = 4'b0001; stb = 4'b0001;
        cycle();
        chk("to_gnt", bus.gnt_o, 4'b0001);
        for (int i = 0; i < TO; i++) cycle();
        chk("to_err", bus.m_err_o, 4'b0001);
        chk("to_scyc", bus.s_cyc_o, 1'b0);
        cyc = '0; stb = '0;
        cycle();
        chk("to_idle", bus.gnt_o, 4'b0000);
        cyc = 4'b0101; stb = 4'b0101;
        cycle();
        chk("to_ptr_adv", bus.gnt_o, 4'b0100);

        // Ack lands on the final count: no abort. Master 0 keeps waiting.
        for (int i = 0; i < TO - 1; i++) cycle();
        sack = 1'b1;
        cycle();
        sack = 1'b0;
        chk("ack7_hold", bus.gnt_o, 4'b0100);
        chk("ack7_noerr", bus.m_err_o, 4'b0000);
        for (int i = 0; i < TO - 1; i++) cycle();
        chk("ack7_reclr", bus.m_err_o, 4'b0000);

        // Asynchronous reset in the middle of master 1's write.
        cyc = 4'b0010; stb = 4'b0010; we = 4'b0010;
        cycle();
        cycle();
        chk("rst_mid_own", bus.gnt_o, 4'b0010);
        sack = 1'b1;
        rst  = 1'b1;
        #1;
        chk("arst_scyc", bus.s_cyc_o, 1'b0);
        chk("arst_gnt", bus.gnt_o, 4'b0000);
        chk("arst_ack", bus.m_ack_o, 4'b0000);
        chk("arst_err", bus.m_err_o, 4'b0000);
        model_reset();
        cycle();
        rst = 1'b0; sack = 1'b0;
        cyc = 4'b1111; stb = 4'b1111;
        cycle();
        chk("rst_prio", bus.gnt_o, 4'b0001);
        cyc = '0; stb = '0;
        cycle();

        // Masters 1 and 3 alternate single writes.
        cyc = 4'b1010; stb = 4'b1010; we = 4'b1010;
        for (int g = 0; g < 4; g++) begin
            int e;
            e = (g % 2 == 0) ? 1 : 3;
            cycle();
            chk("rr_gnt", bus.gnt_o, 128'(1) << e);
            chk("rr_addr", bus.s_addr_o, 32'h1000_0040 + 32'(e * 'h100));
            sack = 1'b1;
            cycle();
            sack = 1'b0;
            cyc[e] = 1'b0;
            cycle();
            chk("rr_bubble", bus.gnt_o, 4'b0000);
            cyc[e] = 1'b1;
        end
        cyc = '0; stb = '0; we = '0;
        cycle();

        // Random traffic with block transfers, stalls and timeouts.
        for (int n = 0; n < 2000; n++) begin
            for (int k = 0; k < NM; k++) begin
                if (act[k]) begin
                    if (exp_err[k]) act[k] = 1'b0;
                    else if (exp_ack[k]) begin
                        beats[k]--;
                        if (beats[k] == 0) act[k] = 1'b0;
                        else wdat[k*32 +: 32] = $urandom;
                    end
                end else if ($urandom_range(3) == 0) begin
                    act[k]           = 1'b1;
                    beats[k]         = 1 + $urandom_range(3);
                    addr[k*32 +: 32] = $urandom;
                    wdat[k*32 +: 32] = $urandom;
                    sel[k*4 +: 4]    = 4'($urandom);
                    we[k]            = 1'($urandom);
                end
                cyc[k] = act[k];
                stb[k] = act[k] && ($urandom_range(9) != 0);
            end
            sdat = $urandom;
            if (stall > 0) begin
                stall--;
                sack = 1'b0;
            end else begin
                if ($urandom_range(39) == 0) stall = 12;
                sack = exp_stb() && ($urandom_range(1) == 0);
            end
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
